// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush/bubble insertion and an
// optional 2-entry skid buffer that makes in_ready a registered signal.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 96,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(32'h00000013),
    parameter int unsigned       SKID       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;
    logic              accept;
    logic              drain;

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign drain     = out_valid & out_ready & ~stall;
    assign accept    = in_valid & in_ready;

    // Skid mode uses the registered ready; single-entry mode can take a new
    // beat whenever the held one leaves this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) begin
            in_ready = ready_q;
        end else begin
            in_ready = (state_q == StEmpty) | (out_ready & ~stall);
        end
    end

    // Occupancy count derived from the state.
    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Entry state machine; ready_q tracks "next state is not TWO".
    // The skid entry is written only when it becomes occupied and is never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= RESET_VAL;
            ready_q <= 1'b1;
        end else if (flush) begin
            // Any beat accepted this cycle is dropped along with held entries.
            state_q <= StEmpty;
            main_q  <= BUBBLE_VAL;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q <= StOne;
                        main_q  <= in_data;
                        ready_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (accept && !drain) begin
                        // Unreachable in single-entry mode since in_ready == drain here.
                        if (SKID != 0) begin
                            state_q <= StTwo;
                            skid_q  <= in_data;
                            ready_q <= 1'b0;
                        end
                    end else if (accept && drain) begin
                        main_q <= in_data;
                    end else if (drain) begin
                        state_q <= StEmpty;
                        main_q  <= BUBBLE_VAL;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    main_q  <= BUBBLE_VAL;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a single-entry instance share stimulus
// and are each compared every cycle against a small FIFO reference model.
module tb_pipe_stage_reg;

    localparam logic [95:0] RESET_V  = 96'h0;
    localparam logic [95:0] BUBBLE_V = 96'h13;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [95:0] in_data;
    logic        stall;
    logic        flush;
    logic        out_ready;

    logic        s1_in_ready, s1_out_valid;
    logic [95:0] s1_out_data;
    logic [1:0]  s1_occ;
    logic        s0_in_ready, s0_out_valid;
    logic [95:0] s0_out_data;
    logic [1:0]  s0_occ;

    int n_cmp;
    int n_mis;

    // Reference model: per instance, a FIFO of up to 2 entries plus the value
    // shown on out_data when nothing is held.
    int          cnt[2];
    logic [95:0] ent[2][2];
    logic [95:0] idle_val[2];

    pipe_stage_reg #(.SKID(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_data(in_data), .stall(stall), .flush(flush), .out_valid(s1_out_valid),
        .out_ready(out_ready), .out_data(s1_out_data), .occupancy(s1_occ)
    );

    pipe_stage_reg #(.SKID(0)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_data(in_data), .stall(stall), .flush(flush), .out_valid(s0_out_valid),
        .out_ready(out_ready), .out_data(s0_out_data), .occupancy(s0_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Apply one cycle of inputs, compare both instances, then advance the model.
    task automatic cyc(input logic r, input logic iv, input logic [95:0] d,
                       input logic st, input logic fl, input logic ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        #1;
        for (int m = 0; m < 2; m++) begin
            logic        exp_rdy;
            logic        exp_vld;
            logic [95:0] exp_dat;
            logic        drn;
            logic        acc;
            if (m == 0) exp_rdy = (cnt[m] < 2);
            else        exp_rdy = (cnt[m] == 0) || (ordy && !st);
            exp_vld = (cnt[m] > 0);
            exp_dat = (cnt[m] > 0) ? ent[m][0] : idle_val[m];
            if (m == 0) begin
                check("s1_in_ready", {95'b0, s1_in_ready}, {95'b0, exp_rdy});
                check("s1_out_valid", {95'b0, s1_out_valid}, {95'b0, exp_vld});
                check("s1_out_data", s1_out_data, exp_dat);
                check("s1_occupancy", {94'b0, s1_occ}, 96'(cnt[m]));
            end else begin
                check("s0_in_ready", {95'b0, s0_in_ready}, {95'b0, exp_rdy});
                check("s0_out_valid", {95'b0, s0_out_valid}, {95'b0, exp_vld});
                check("s0_out_data", s0_out_data, exp_dat);
                check("s0_occupancy", {94'b0, s0_occ}, 96'(cnt[m]));
            end
            if (r) begin
                cnt[m]      = 0;
                idle_val[m] = RESET_V;
            end else if (fl) begin
                cnt[m]      = 0;
                idle_val[m] = BUBBLE_V;
            end else begin
                drn = (cnt[m] > 0) && ordy && !st;
                acc = iv && exp_rdy;
                if (drn) begin
                    ent[m][0] = ent[m][1];
                    cnt[m]    = cnt[m] - 1;
                end
                if (acc) begin
                    ent[m][cnt[m]] = d;
                    cnt[m]         = cnt[m] + 1;
                end
                if (drn && cnt[m] == 0) idle_val[m] = BUBBLE_V;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        for (int m = 0; m < 2; m++) begin
            cnt[m]      = 0;
            idle_val[m] = RESET_V;
            ent[m][0]   = '0;
            ent[m][1]   = '0;
        end
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);

        // Reset held with a valid beat offered; first accept after release.
        cyc(1, 1, 96'hA, 0, 0, 1);
        cyc(1, 1, 96'hA, 0, 0, 1);
        cyc(0, 1, 96'hA, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);

        // Streaming 1..4 at full throughput.
        for (int i = 1; i <= 4; i++) cyc(0, 1, 96'(i), 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);

        // Stall fill: 6 goes to skid while 5 is stalled, 7 waits upstream.
        cyc(0, 1, 96'h5, 0, 0, 1);
        cyc(0, 1, 96'h6, 1, 0, 1);
        cyc(0, 1, 96'h7, 1, 0, 1);
        cyc(0, 1, 96'h7, 0, 0, 1);
        cyc(0, 1, 96'h7, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);

        // Flush while full, with beat 8 offered in the flush cycle.
        cyc(0, 1, 96'hB1, 1, 0, 1);
        cyc(0, 1, 96'hB2, 1, 0, 1);
        cyc(0, 1, 96'h8, 1, 1, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);

        // Drain to empty with a single beat.
        cyc(0, 1, 96'h9, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);

        // Back-pressure, then release with a replacement beat in the same cycle.
        cyc(0, 1, 96'hC1, 0, 0, 0);
        cyc(0, 1, 96'hC2, 0, 0, 0);
        cyc(0, 1, 96'hC2, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);
        cyc(0, 0, 96'h0, 0, 0, 1);

        // Randomised traffic with occasional stall, flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic        r, iv, st, fl, ordy;
            logic [95:0] d;
            r    = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 99) < 4);
            st   = ($urandom_range(0, 99) < 25);
            iv   = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 70);
            d    = {$urandom, $urandom, $urandom};
            cyc(r, iv, d, st, fl, ordy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
